// File: rtl/lb_fifo_core.sv
// rtl/lb_fifo_core.sv - single-clock FIFO core with registered pop data; optional FIFO_BYPASS_EN empty-path forwarding
module lb_fifo_core #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             flush,
    input  logic             wen,
    input  logic             ren,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic             bypass;

    // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Status is decoded from the registered count only.
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

`ifdef FIFO_BYPASS_EN
    assign bypass = clk_en & wen & ren & ~flush & empty;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word never touches memory, so it is not a push.
    assign push = clk_en & wen & ~flush & (~full | ren) & ~bypass;
    assign pop  = clk_en & ren & ~flush & ~empty;

    // Storage array: written on push only, never cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers and occupancy, with reset over flush over push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clk_en && flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Output register: read-before-write on a shared address, so a full
    // push+pop returns the old word; valid_out pulses once per pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else if (clk_en) begin
            if (flush) begin
                valid_out <= 1'b0;
            end else if (bypass) begin
                data_out  <= data_in;
                valid_out <= 1'b1;
            end else if (pop) begin
                data_out  <= mem[rd_ptr];
                valid_out <= 1'b1;
            end else begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lb_fifo_core.sv
// tb/tb_lb_fifo_core.sv - directed scoreboard bench for lb_fifo_core at DEPTH=4
module tb_lb_fifo_core;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             clk_en = 1'b0;
    logic             flush = 1'b0;
    logic             wen = 1'b0;
    logic             ren = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] model [$];
    logic [WIDTH-1:0] sb [$];
    logic             exp_valid;
    logic [WIDTH-1:0] exp_data;
    int               max_count;

    lb_fifo_core #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .flush     (flush),
        .wen       (wen),
        .ren       (ren),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .empty     (empty),
        .full      (full),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(model.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(model.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(model.size() == DEPTH));
        chk({tag, ".valid"}, 32'(valid_out), 32'(exp_valid));
        chk({tag, ".data"}, 32'(data_out), 32'(exp_data));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model.delete();
        sb.delete();
        exp_valid = 1'b0;
        exp_data  = '0;
        check_all("reset");
    endtask

    // One clock: predict with the queue model, drive, then compare after the edge.
    task automatic cyc(input string tag, input logic ce, input logic f, input logic w,
                       input logic r, input logic [WIDTH-1:0] d);
        logic produced;
        logic by;
        produced = 1'b0;
        by = 1'b0;
        if (ce) begin
            if (f) begin
                model.delete();
                exp_valid = 1'b0;
            end else begin
`ifdef FIFO_BYPASS_EN
                if (w && r && model.size() == 0) begin
                    by = 1'b1;
                    sb.push_back(d);
                    produced = 1'b1;
                end
`endif
                if (!by) begin
                    logic do_pop;
                    logic do_push;
                    do_pop  = r && model.size() > 0;
                    do_push = w && (model.size() < DEPTH || r);
                    if (do_pop) begin
                        sb.push_back(model.pop_front());
                        produced = 1'b1;
                    end
                    if (do_push) begin
                        model.push_back(d);
                    end
                end
                exp_valid = produced;
            end
        end
        clk_en = ce; flush = f; wen = w; ren = r; data_in = d;
        @(posedge clk);
        #1;
        clk_en = 1'b0; flush = 1'b0; wen = 1'b0; ren = 1'b0;
        if (produced && sb.size() > 0) begin
            exp_data = sb.pop_front();
        end
        if (model.size() > max_count) max_count = model.size();
        check_all(tag);
    endtask

    initial begin
        max_count = 0;
        do_reset();
        for (int i = 0; i < 5; i++) cyc("idle", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);

        // Fill to full, overflow push dropped, drain in order.
        cyc("fill", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0011);
        cyc("fill", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0022);
        cyc("fill", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0033);
        cyc("fill", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0044);
        cyc("overflow", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0055);
        cyc("drain", 1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
        cyc("hold_ce0", 1'b0, 1'b0, 1'b1, 1'b1, 16'h0066);
        cyc("drain", 1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
        cyc("drain", 1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
        cyc("drain", 1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
        cyc("underflow", 1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
        cyc("idle2", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);

        // Full with simultaneous push and pop: old word out, AA emerges last.
        for (int i = 1; i <= 4; i++) cyc("fill2", 1'b1, 1'b0, 1'b1, 1'b0, 16'(i));
        cyc("full_pp", 1'b1, 1'b0, 1'b1, 1'b1, 16'h00AA);
        for (int i = 0; i < 5; i++) cyc("drain2", 1'b1, 1'b0, 1'b0, 1'b1, 16'h0);

        // Flush gated by clk_en, then flush discarding a same-cycle push.
        for (int i = 0; i < 3; i++) cyc("fill3", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0200 + 16'(i));
        cyc("flush_ce0", 1'b0, 1'b1, 1'b1, 1'b1, 16'h0BAD);
        cyc("flush", 1'b1, 1'b1, 1'b1, 1'b0, 16'h0BAD);
        cyc("post_flush", 1'b1, 1'b0, 1'b0, 1'b1, 16'h0);

        // Wrap-around with push/pop pairs, then a push+pop at count 1.
        max_count = 0;
        for (int i = 0; i < 10; i++) begin
            cyc("wrap_push", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0100 + 16'(i));
            cyc("wrap_pop", 1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
        end
        chk("wrap_max_count", 32'(max_count), 32'd1);
        cyc("one_push", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0301);
        cyc("one_pp", 1'b1, 1'b0, 1'b1, 1'b1, 16'h0302);
        cyc("one_pop", 1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
        cyc("idle3", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);

        // Empty push+pop: bypass or plain push depending on build.
        cyc("empty_pp", 1'b1, 1'b0, 1'b1, 1'b1, 16'h5A5A);
        cyc("after_pp", 1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
        cyc("idle4", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);

        chk("sb_empty", 32'(sb.size()), 32'd0);

        // Reset returns everything to the initial state.
        cyc("prefill", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0777);
        cyc("prepop", 1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
